// File: rtl/fetch_unit_pkg.sv
// Shared core constants for the instruction fetch path.
//   Nop       : instruction presented on an empty fetch queue (addi x0, x0, 0)
//   PcIncr    : byte step between sequential 32-bit instructions
//   cnt_width : width of a counter holding 0..depth inclusive
package fetch_unit_pkg;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam int unsigned PcIncr = 4;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: circular buffer with a synchronous flush.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   flush     : drop every entry at the next edge (wins over push/pop)
//   push      : write wdata; accepted when not full, or when full with a pop
//   pop       : discard the head entry; ignored when empty
//   wdata     : entry to write
//   rdata     : head entry (undefined when empty)
//   empty     : no entries held
//   count     : number of entries held (0..Depth)
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [Width-1:0]               wdata,
  output logic [Width-1:0]               rdata,
  output logic                           empty,
  output logic [cnt_width(Depth)-1:0]    count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = cnt_width(Depth);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign pop_ok  = pop && !empty;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to instruction memory,
// queues the in-order responses with their PCs, and presents the head to decode.
// Requests are credit-limited so queued + in-flight never exceeds Depth; on a
// redirect the queue is flushed and all in-flight responses are dropped.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   stall       : decode hold; head is not consumed
//   redirect    : taken branch/jump; flush and restart at redirect_pc
//   redirect_pc : restart address (bits [1:0] ignored)
//   imem_req    : request valid, imem_addr : word-aligned request address
//   imem_gnt    : request accepted
//   imem_rvalid : in-order response valid, imem_rdata : response word
//   ins, pc_out : queue-head instruction and PC (NOP / 0 when empty)
//   ins_valid   : queue head valid
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          WordSize = 32,
  parameter logic [WordSize-1:0]  ResetPc  = '0,
  parameter int unsigned          Depth    = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                redirect,
  input  logic [WordSize-1:0] redirect_pc,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         ins,
  output logic [WordSize-1:0] pc_out,
  output logic                ins_valid
);

  localparam int unsigned CntW   = cnt_width(Depth);
  localparam int unsigned CredW  = CntW + 1;
  localparam int unsigned EntryW = 32 + WordSize;
  localparam logic [WordSize-1:0] PcStep = WordSize'(PcIncr);

  logic [WordSize-1:0] fetch_pc_q, fetch_pc_d;
  logic [WordSize-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic [CntW-1:0]     discard_q, discard_d;
  logic [CntW-1:0]     fifo_count;
  logic [CredW-1:0]    credits_used;
  logic [EntryW-1:0]   head;
  logic [WordSize-1:0] redirect_base;
  logic                fifo_empty, grant, push, pop;
  logic                unused_redirect_lsbs;

  assign redirect_base        = {redirect_pc[WordSize-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Queued entries plus in-flight requests bound the queue's future occupancy.
  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req     = rstn && !redirect && (credits_used < CredW'(Depth));
  assign imem_addr    = fetch_pc_q;
  assign grant        = imem_req && imem_gnt;

  assign push      = imem_rvalid && (discard_q == '0) && !redirect;
  assign ins_valid = !fifo_empty;
  assign pop       = ins_valid && !stall && !redirect;
  assign ins       = fifo_empty ? Nop : head[EntryW-1 -: 32];
  assign pc_out    = fifo_empty ? '0  : head[WordSize-1:0];

  fetch_fifo #(
    .Depth (Depth),
    .Width (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata, resp_pc_q}),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q;

    case ({grant, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      // Everything still in flight after this edge belongs to the old path.
      discard_d  = outstanding_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PcStep;
      if (imem_rvalid) begin
        if (discard_q != '0) discard_d = discard_q - CntW'(1);
        else                 resp_pc_d = resp_pc_q + PcStep;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q    <= ResetPc;
      resp_pc_q     <= ResetPc;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model returning in-order
// responses, a scoreboard of queued PCs, a directed vector table and
// randomized traffic with stalls, redirects and a mid-run reset.
module tb_fetch_unit;

  localparam int unsigned WordSize = 32;
  localparam int unsigned Depth    = 2;
  localparam logic [31:0] ResetPc  = 32'h0;
  localparam logic [31:0] NopWord  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ins;
  logic [31:0] pc_out;
  logic        ins_valid;

  fetch_unit #(
    .WordSize (WordSize),
    .ResetPc  (ResetPc),
    .Depth    (Depth)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ins         (ins),
    .pc_out      (pc_out),
    .ins_valid   (ins_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory side: requests granted but not yet answered, oldest first.
  logic [31:0] mq_addr[$];
  int          mq_cyc[$];
  bit          mq_stale[$];
  // Decode side: PCs of responses that should sit in the fetch queue.
  logic [31:0] fq[$];
  logic [31:0] exp_fetch, exp_cons;
  bit          rand_gnt = 1'b0;
  bit          rand_lat = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq_addr.delete();
    mq_cyc.delete();
    mq_stale.delete();
    fq.delete();
    exp_fetch = ResetPc;
    exp_cons  = ResetPc;
  endtask

  // Called at a negedge: drive inputs for the next posedge, check outputs,
  // then advance the reference model to the state after that posedge.
  task automatic drive_and_check(input bit st, input bit rd, input logic [31:0] rpc,
                                 input bit hold);
    bit          rv, gn, exp_req, exp_valid, stale;
    logic [31:0] a;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    gn = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
    rv = 1'b0;
    if (!hold && mq_addr.size() > 0 && mq_cyc[0] < cyc)
      rv = rand_lat ? ($urandom_range(0, 2) != 0) : 1'b1;
    imem_gnt    = gn;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(mq_addr[0]) : $urandom;
    #1;
    exp_req   = !rd && ((fq.size() + mq_addr.size()) < Depth);
    exp_valid = (fq.size() != 0);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check("ins_valid", {31'b0, ins_valid}, {31'b0, exp_valid});
    check("imem_addr", imem_addr, exp_fetch);
    check("imem_addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
    if (exp_valid) begin
      check("pc_out", pc_out, fq[0]);
      check("ins", ins, mem_word(fq[0]));
    end else begin
      check("pc_out_empty", pc_out, 32'h0);
      check("ins_empty", ins, NopWord);
    end
    if (exp_valid && !st && !rd) check("pop_order", pc_out, exp_cons);

    if (rd) begin
      fq.delete();
      foreach (mq_stale[i]) mq_stale[i] = 1'b1;
      exp_fetch = {rpc[31:2], 2'b00};
      exp_cons  = {rpc[31:2], 2'b00};
    end else if (exp_valid && !st) begin
      void'(fq.pop_front());
      exp_cons += 32'd4;
    end
    if (rv) begin
      a = mq_addr.pop_front();
      void'(mq_cyc.pop_front());
      stale = mq_stale.pop_front();
      if (!stale && !rd) fq.push_back(a);
    end
    if (exp_req && gn) begin
      mq_addr.push_back(exp_fetch);
      mq_cyc.push_back(cyc);
      mq_stale.push_back(1'b0);
      exp_fetch += 32'd4;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit hold);
    drive_and_check(st, rd, rpc, hold);
    advance();
  endtask

  // Entered at a negedge; asserts reset between edges and releases it at a
  // later negedge.
  task automatic async_reset();
    #2;
    rstn        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    #1;
    check("rst_ins_valid", {31'b0, ins_valid}, 32'h0);
    check("rst_ins", ins, NopWord);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_imem_addr", imem_addr, ResetPc);
    check("rst_imem_req_hold", {31'b0, imem_req}, 32'h0);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit          st;
    bit          rd;
    logic [31:0] rpc;
    bit          hold;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[13];

  initial begin
    // Streaming from reset, then a redirect to 0x103 with two requests in flight.
    vt[0]  = '{0, 0, 32'h0,   0, 1, 32'h000, 0, 32'h000};
    vt[1]  = '{0, 0, 32'h0,   0, 1, 32'h004, 0, 32'h000};
    vt[2]  = '{0, 0, 32'h0,   0, 0, 32'h008, 1, 32'h000};
    vt[3]  = '{0, 0, 32'h0,   0, 1, 32'h008, 1, 32'h004};
    vt[4]  = '{0, 0, 32'h0,   0, 1, 32'h00C, 0, 32'h000};
    vt[5]  = '{0, 0, 32'h0,   0, 0, 32'h010, 1, 32'h008};
    vt[6]  = '{0, 0, 32'h0,   0, 1, 32'h010, 1, 32'h00C};
    vt[7]  = '{0, 0, 32'h0,   1, 1, 32'h014, 0, 32'h000};
    vt[8]  = '{0, 1, 32'h103, 1, 0, 32'h018, 0, 32'h000};
    vt[9]  = '{0, 0, 32'h0,   0, 0, 32'h100, 0, 32'h000};
    vt[10] = '{0, 0, 32'h0,   0, 1, 32'h100, 0, 32'h000};
    vt[11] = '{0, 0, 32'h0,   0, 1, 32'h104, 0, 32'h000};
    vt[12] = '{0, 0, 32'h0,   0, 0, 32'h108, 1, 32'h100};

    model_clear();
    @(negedge clk);
    async_reset();

    for (int i = 0; i < 13; i++) begin
      drive_and_check(vt[i].st, vt[i].rd, vt[i].rpc, vt[i].hold);
      check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].req});
      check($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
      check($sformatf("vec%0d_valid", i), {31'b0, ins_valid}, {31'b0, vt[i].valid});
      check($sformatf("vec%0d_pc", i), pc_out, vt[i].pc);
      advance();
    end

    // Stall: queue fills to Depth, requests stop, head holds; then drain.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    drive_and_check(1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_req_low", {31'b0, imem_req}, 32'h0);
    check("stall_head", pc_out, exp_cons);
    check("stall_full", fq.size() == Depth ? {31'b0, ins_valid} : 32'h0,
          fq.size() == Depth ? 32'h1 : 32'h0);
    advance();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect coinciding with a response: that response and the rest dropped.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h2000, 1'b0);
    drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
    check("redir_rv_empty", {31'b0, ins_valid}, 32'h0);
    advance();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // PC wrap at the top of the address space.
    begin
      bit seen = 1'b0;
      cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
      for (int i = 0; i < 8 && !seen; i++) begin
        drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
        if (imem_req) begin
          seen = 1'b1;
          check("wrap_from", imem_addr, 32'hFFFF_FFFC);
          advance();
          drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
          check("wrap_addr", imem_addr, 32'h0000_0000);
        end
        advance();
      end
      if (!seen) check("wrap_grant_timeout", 32'h0, 32'h1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    end

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    async_reset();
    drive_and_check(1'b0, 1'b0, 32'h0, 1'b0);
    check("post_rst_req", {31'b0, imem_req}, 32'h1);
    check("post_rst_addr", imem_addr, ResetPc);
    advance();

    // Randomized traffic.
    rand_gnt = 1'b1;
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      cycle(($urandom % 10) < 3, ($urandom % 25) == 0, $urandom, ($urandom % 8) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: WordSize, default 32, address/PC width; ResetPc, default 0, first fetch address; Depth, default 2, fetch-queue entries and maximum in-flight requests (>=1).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  downstream hold; when high, the queue head is not consumed.
REQ-005 redirect  in  1  branch/jump taken; flush and restart fetch.
REQ-006 redirect_pc  in  WordSize  new fetch address; bits [1:0] are ignored (treated as 0).
REQ-007 imem_req  out  1  instruction-memory request valid.
REQ-008 imem_addr  out  WordSize  request address; bits [1:0] are always 0.
REQ-009 imem_gnt  in  1  request accepted this cycle (when imem_req high).
REQ-010 imem_rvalid  in  1  response valid; responses return in order, no earlier than the cycle after grant.
REQ-011 imem_rdata  in  32  response instruction word.
REQ-012 ins  out  32  queue-head instruction; feeds decode ins.
REQ-013 pc_out  out  WordSize  queue-head PC; feeds decode pc_in.
REQ-014 ins_valid  out  1  queue head valid.

Function
REQ-015 fetch_pc SHALL advance by 4 on each cycle with imem_req && imem_gnt.
REQ-016 imem_req SHALL be high iff redirect is low and (occupancy + outstanding) < Depth; imem_addr = fetch_pc.
REQ-017 outstanding SHALL increment on grant, decrement on imem_rvalid, and be unchanged when both occur in one cycle.
REQ-018 An imem_rvalid while discard > 0 SHALL be dropped and SHALL decrement discard; otherwise {imem_rdata, resp_pc} SHALL be pushed and resp_pc SHALL advance by 4.
REQ-019 Credit rule SHALL guarantee a push never finds the queue full; simultaneous push and pop SHALL be legal at any occupancy.
REQ-020 ins_valid = queue not empty; pop SHALL occur when ins_valid && !stall.
REQ-021 When the queue is empty, ins SHALL be 32'h00000013 (NOP) and pc_out SHALL be 0.
REQ-022 Response-to-ins_valid latency SHALL be 1 cycle (registered push, head visible next cycle).
REQ-023 Redirect SHALL take priority over all other events in that cycle: queue cleared, no pop, no push, imem_req low.
REQ-024 On redirect: fetch_pc and resp_pc <= {redirect_pc[WordSize-1:2], 2'b00}; discard <= outstanding + grant_this_cycle - rvalid_this_cycle.
REQ-025 Redirect while discard > 0 SHALL still apply REQ-024 (discard recomputed from total outstanding).
REQ-026 fetch_pc and resp_pc SHALL wrap modulo 2^WordSize.
REQ-027 imem_rvalid with outstanding == 0 is illegal; the design is not required to handle it.

Reset
REQ-028 On rstn low: fetch_pc = resp_pc = ResetPc, outstanding = discard = 0, queue empty, ins_valid = 0, ins = NOP, pc_out = 0.
REQ-029 imem_req SHALL be low during reset and may assert in the first cycle after rstn rises.
REQ-030 Reset mid-transaction SHALL abandon in-flight requests; memory is reset with the core.

Structure
REQ-031 NOP encoding (32'h00000013) and the PC increment constant (4) SHALL live in the shared core package.
REQ-032 Queue SHALL be a sub-module fetch_fifo (parameter Depth, width 32+WordSize, synchronous flush input, push/pop/empty/count ports).
REQ-033 Counters outstanding/discard SHALL be $clog2(Depth+1) bits wide.

Verification
REQ-034 Reset release, imem_gnt=1, 1-cycle response latency, stall=0 -> imem_addr 0,4,8,...; ins_valid from cycle 3; pc_out sequence 0,4,8.
REQ-035 stall=1 for 5 cycles -> at most Depth=2 entries queued, imem_req low once credits exhausted, head held stable; release drains in order.
REQ-036 Redirect to 0x103 with 2 requests in flight -> both responses dropped, next imem_addr 0x100, next pc_out 0x100.
REQ-037 Redirect in the same cycle as a grant and an rvalid -> discard = outstanding, no push, queue empty next cycle.
REQ-038 fetch_pc = 0xFFFFFFFC, grant -> next imem_addr 0x00000000.
REQ-039 rstn asserted mid-burst -> all outputs at reset values immediately (asynchronous), first request after release at ResetPc.
